// File: rtl/lsu_dmem_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store controller: size codes, FSM encoding.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package lsu_dmem_ctrl_pkg;

  localparam int WORD_WIDTH = 32;

  // Access size codes carried on req_size
  localparam logic [1:0] MEM_SZ_B   = 2'b00;
  localparam logic [1:0] MEM_SZ_H   = 2'b01;
  localparam logic [1:0] MEM_SZ_W   = 2'b10;
  localparam logic [1:0] MEM_SZ_ILL = 2'b11;

  // Controller state encoding
  localparam logic [2:0] LSU_IDLE   = 3'd0;
  localparam logic [2:0] LSU_EXC    = 3'd1;
  localparam logic [2:0] LSU_LD_RD  = 3'd2;
  localparam logic [2:0] LSU_LD_RSP = 3'd3;
  localparam logic [2:0] LSU_ST_WR  = 3'd4;
  localparam logic [2:0] LSU_SB_RD  = 3'd5;
  localparam logic [2:0] LSU_SB_MRG = 3'd6;

  // Request attributes held for the whole access
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       sgn;
  } lsu_attr_t;

  // Misaligned or illegal-size accesses never touch memory
  function automatic logic lsu_bad_access(input logic [1:0] size, input logic [1:0] lo);
    return (size == MEM_SZ_ILL) ||
           ((size == MEM_SZ_W) && (lo != 2'b00)) ||
           ((size == MEM_SZ_H) && lo[0]);
  endfunction

endpackage

// File: rtl/lsu_dmem_ctrl_if.sv
// Bundle of pipeline request/response and data-memory strobes around the LSU.
// Latency: n/a (wires only).
// Backpressure: req_ready from the controller; responses and memory have none.
interface lsu_dmem_ctrl_if
  import lsu_dmem_ctrl_pkg::*;
#(
  parameter int W = WORD_WIDTH
);
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [1:0]   req_size;
  logic         req_signed;
  logic [W-1:0] req_addr;
  logic [W-1:0] req_wdata;
  logic         resp_valid;
  logic         resp_exc;
  logic [W-1:0] resp_data;
  logic         read_en;
  logic [W-1:0] read_addr;
  logic [W-1:0] read_data;
  logic         write_en;
  logic [W-1:0] write_addr;
  logic [W-1:0] write_data;

  // Environment side: pipeline plus data memory
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, read_data,
    input  req_ready, resp_valid, resp_exc, resp_data,
           read_en, read_addr, write_en, write_addr, write_data
  );

  // Controller side
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, read_data,
    output req_ready, resp_valid, resp_exc, resp_data,
           read_en, read_addr, write_en, write_addr, write_data
  );
endinterface

// File: rtl/lsu_dmem_ctrl_lane_align.sv
// Byte/half lane extraction with extension for loads, lane merge for sub-word stores.
// Latency: purely combinational.
// Backpressure: none.
module lsu_dmem_ctrl_lane_align
  import lsu_dmem_ctrl_pkg::*;
#(
  parameter int W          = WORD_WIDTH,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [W-1:0] rd_word,
  input  logic [W-1:0] wdata,
  input  logic [1:0]   lane_addr,
  input  logic [1:0]   size,
  input  logic         sgn,
  output logic [W-1:0] ld_val,
  output logic [W-1:0] st_word
);

  logic [1:0]  lane;
  logic        hsel;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Big-endian mirrors the lane (3-addr == ~addr); half select follows lane msb
  assign lane = BIG_ENDIAN ? ~lane_addr : lane_addr;
  assign hsel = lane[1];

  // Extract the addressed field and extend it to a full word
  always_comb begin
    byte_v = rd_word[{lane, 3'b000} +: 8];
    half_v = rd_word[{hsel, 4'b0000} +: 16];
    case (size)
      MEM_SZ_B: ld_val = {{(W-8){sgn & byte_v[7]}}, byte_v};
      MEM_SZ_H: ld_val = {{(W-16){sgn & half_v[15]}}, half_v};
      default:  ld_val = rd_word;
    endcase
  end

  // Replace the addressed lane(s) of the old word with right-justified store data
  always_comb begin
    st_word = rd_word;
    case (size)
      MEM_SZ_B: st_word[{lane, 3'b000} +: 8]  = wdata[7:0];
      MEM_SZ_H: st_word[{hsel, 4'b0000} +: 16] = wdata[15:0];
      default:  st_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store initiator between MEM stage and word-addressed data memory (RMW for sub-word stores).
// Latency: word store 1, load 2, sub-word store 2, exception 1 cycle(s) from accept edge to resp_valid.
// Backpressure: req_ready only in IDLE; resp_valid is a 1-cycle pulse that cannot be stalled.
module lsu_dmem_ctrl
  import lsu_dmem_ctrl_pkg::*;
#(
  parameter int W          = WORD_WIDTH,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  lsu_dmem_ctrl_if.slave   bus
);

  logic [2:0]   state;
  logic [2:0]   state_nxt;
  lsu_attr_t    attr;
  logic [W-1:0] addr_q;
  logic [W-1:0] wdata_q;
  logic         accept;
  logic [W-1:0] word_addr;
  logic [W-1:0] ld_val;
  logic [W-1:0] st_word;

  assign accept    = bus.req_valid && (state == LSU_IDLE);
  assign word_addr = {addr_q[W-1:2], 2'b00};

  lsu_dmem_ctrl_lane_align #(
    .W          (W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_align (
    .rd_word   (bus.read_data),
    .wdata     (wdata_q),
    .lane_addr (addr_q[1:0]),
    .size      (attr.size),
    .sgn       (attr.sgn),
    .ld_val    (ld_val),
    .st_word   (st_word)
  );

  // Next-state: classify at accept, then walk the fixed sequence back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      LSU_IDLE: begin
        if (accept) begin
          if (lsu_bad_access(bus.req_size, bus.req_addr[1:0])) state_nxt = LSU_EXC;
          else if (!bus.req_we)                                 state_nxt = LSU_LD_RD;
          else if (bus.req_size == MEM_SZ_W)                    state_nxt = LSU_ST_WR;
          else                                                  state_nxt = LSU_SB_RD;
        end
      end
      LSU_LD_RD: state_nxt = LSU_LD_RSP;
      LSU_SB_RD: state_nxt = LSU_SB_MRG;
      default:   state_nxt = LSU_IDLE;
    endcase
  end

  // State register and request latch; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= LSU_IDLE;
      attr    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        attr.we   <= bus.req_we;
        attr.size <= bus.req_size;
        attr.sgn  <= bus.req_signed;
        addr_q    <= bus.req_addr;
        wdata_q   <= bus.req_wdata;
      end
    end
  end

  // Outputs decoded from state; read and write strobes live in disjoint states
  always_comb begin
    bus.req_ready  = (state == LSU_IDLE);
    bus.resp_valid = 1'b0;
    bus.resp_exc   = 1'b0;
    bus.resp_data  = '0;
    bus.read_en    = 1'b0;
    bus.read_addr  = '0;
    bus.write_en   = 1'b0;
    bus.write_addr = '0;
    bus.write_data = '0;
    case (state)
      LSU_EXC: begin
        bus.resp_valid = 1'b1;
        bus.resp_exc   = 1'b1;
      end
      LSU_LD_RD, LSU_SB_RD: begin
        bus.read_en   = 1'b1;
        bus.read_addr = word_addr;
      end
      LSU_LD_RSP: begin
        bus.resp_valid = 1'b1;
        bus.resp_data  = ld_val;
      end
      LSU_ST_WR: begin
        bus.write_en   = 1'b1;
        bus.write_addr = word_addr;
        bus.write_data = wdata_q;
        bus.resp_valid = 1'b1;
      end
      LSU_SB_MRG: begin
        bus.write_en   = 1'b1;
        bus.write_addr = word_addr;
        bus.write_data = st_word;
        bus.resp_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Drives a little-endian and a big-endian controller in lockstep against byte-level reference models.
// Latency: n/a (bench).
// Backpressure: requests issued only when both controllers show req_ready.
module tb_lsu_dmem_ctrl;
  import lsu_dmem_ctrl_pkg::*;

  typedef struct {
    logic        exc;
    logic [31:0] data;
    int          cyc;
    int          nrd;
    int          nwr;
    int          widx;
    logic [31:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic        req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  logic [1:0]  rdy, rsp_vld, rsp_exc, r_en, w_en;
  logic [31:0] rsp_dat [2];
  logic [31:0] r_addr [2];
  logic [31:0] w_addr [2];
  logic [31:0] w_dat [2];
  logic [31:0] rdata [2];
  logic [31:0] dmem [2][256];

  logic [7:0]  mb [2][1024];
  exp_t        q0[$];
  exp_t        q1[$];
  int          nrd [2];
  int          nwr [2];
  bit          mchk [2];
  int          mw [2];
  logic [31:0] mword [2];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;

  // Instance 0 little-endian, instance 1 big-endian; each has its own memory
  for (genvar g = 0; g < 2; g++) begin : g_inst
    lsu_dmem_ctrl_if #(.W(32)) bus ();
    assign bus.req_valid  = req_valid;
    assign bus.req_we     = req_we;
    assign bus.req_size   = req_size;
    assign bus.req_signed = req_signed;
    assign bus.req_addr   = req_addr;
    assign bus.req_wdata  = req_wdata;
    assign bus.read_data  = rdata[g];
    assign rdy[g]         = bus.req_ready;
    assign rsp_vld[g]     = bus.resp_valid;
    assign rsp_exc[g]     = bus.resp_exc;
    assign rsp_dat[g]     = bus.resp_data;
    assign r_en[g]        = bus.read_en;
    assign r_addr[g]      = bus.read_addr;
    assign w_en[g]        = bus.write_en;
    assign w_addr[g]      = bus.write_addr;
    assign w_dat[g]       = bus.write_data;
    lsu_dmem_ctrl #(.W(32), .BIG_ENDIAN(g == 1)) dut (.clk(clk), .rst(rst), .bus(bus));
  end

  // 1-cycle registered-read data memories
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (w_en[g]) dmem[g][w_addr[g][9:2]] <= w_dat[g];
      if (r_en[g]) rdata[g] <= dmem[g][r_addr[g][9:2]];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d @cyc %0d: got 0x%08h expected 0x%08h", name, g, cyc, act, exp);
    end
  endtask

  // Reference model: memory as bytes; instance g=1 reads multi-byte values big-endian
  function automatic logic [31:0] word_of(input int g, input int w);
    logic [31:0] v = '0;
    for (int k = 0; k < 4; k++) v[8*((g == 1) ? 3 - k : k) +: 8] = mb[g][4*w + k];
    return v;
  endfunction

  function automatic logic [31:0] mdl_load(input int g, input int a, input int n, input bit sgn);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(mb[g][a + i]) << (8 * ((g == 1) ? n - 1 - i : i)));
    if (sgn && n < 4 && v[8*n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic mdl_store(input int g, input int a, input int n, input logic [31:0] wd);
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      t = wd >> (8 * ((g == 1) ? n - 1 - i : i));
      mb[g][a + i] = t[7:0];
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (rdy != 2'b11 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", 0, {30'b0, rdy}, 32'd3);
  endtask

  // Issue one request; k*v overrides the model with a literal expectation
  // (load result for loads, resulting memory word for stores)
  task automatic do_op(input bit we, input logic [1:0] sz, input bit sgn, input int a,
                       input logic [31:0] wd, input bit k0v, input logic [31:0] k0,
                       input bit k1v, input logic [31:0] k1);
    int n;
    bit exc;
    exp_t e;
    wait_ready();
    if (rdy != 2'b11) return;
    req_we = we; req_size = sz; req_signed = sgn; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = (sz == MEM_SZ_B) ? 1 : (sz == MEM_SZ_H) ? 2 : 4;
    exc = (sz == MEM_SZ_ILL) || (sz == MEM_SZ_W && a[1:0] != 2'b00) || (sz == MEM_SZ_H && a[0]);
    for (int g = 0; g < 2; g++) begin
      e.exc  = exc;
      e.cyc  = cyc + ((exc || (we && sz == MEM_SZ_W)) ? 1 : 2);
      e.nrd  = (!exc && (!we || sz != MEM_SZ_W)) ? 1 : 0;
      e.nwr  = (!exc && we) ? 1 : 0;
      e.widx = (a >> 2) & 255;
      e.data = '0;
      if (!exc && we) mdl_store(g, a, n, wd);
      if (!exc && !we) e.data = mdl_load(g, a, n, sgn);
      e.word = word_of(g, e.widx);
      if (!exc && ((g == 0 && k0v) || (g == 1 && k1v))) begin
        if (we) e.word = (g == 0) ? k0 : k1;
        else    e.data = (g == 0) ? k0 : k1;
      end
      if (g == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk);
    #1;
    // Garbage while busy must be ignored
    req_valid = 1'($urandom_range(0, 1));
    req_we = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic op(input bit we, input logic [1:0] sz, input bit sgn, input int a, input logic [31:0] wd);
    do_op(we, sz, sgn, a, wd, 1'b0, '0, 1'b0, '0);
  endtask

  // Reset in SB_RD: no write, no response, ready immediately
  task automatic abort_rmw(input int a);
    wait_ready();
    req_we = 1'b1; req_size = MEM_SZ_B; req_signed = 1'b0; req_addr = a; req_wdata = 32'h5A;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) chk("abort_in_read", g, {31'b0, r_en[g]}, 32'd1);
    rst = 1'b0;
    req_valid = 1'b0;
    #2;
    for (int g = 0; g < 2; g++) begin
      chk("abort_ready", g, {31'b0, rdy[g]}, 32'd1);
      chk("abort_strobes", g, {30'b0, r_en[g], w_en[g]}, 32'd0);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) chk("abort_mem", g, dmem[g][(a >> 2) & 255], word_of(g, (a >> 2) & 255));
  endtask

  task automatic mon_step(input int g);
    exp_t e = '{default: 0};
    bit have;
    if (!rst) begin
      nrd[g] = 0; nwr[g] = 0; mchk[g] = 1'b0;
      chk("reset_outputs", g, {31'b0, (rdy[g] && !rsp_vld[g] && !rsp_exc[g] && rsp_dat[g] == 0 &&
          !r_en[g] && !w_en[g] && r_addr[g] == 0 && w_addr[g] == 0 && w_dat[g] == 0)}, 32'd1);
      return;
    end
    if (mchk[g]) begin
      chk("mem_word", g, dmem[g][mw[g]], mword[g]);
      mchk[g] = 1'b0;
    end
    have = (g == 0) ? (q0.size() != 0) : (q1.size() != 0);
    if (have) e = (g == 0) ? q0[0] : q1[0];
    if (r_en[g] || w_en[g]) begin
      chk("strobe_excl", g, {31'b0, r_en[g] & w_en[g]}, 32'd0);
      chk("strobe_owner", g, {31'b0, have}, 32'd1);
      if (r_en[g]) begin nrd[g]++; chk("read_addr", g, r_addr[g], 32'(e.widx * 4)); end
      if (w_en[g]) begin nwr[g]++; chk("write_addr", g, w_addr[g], 32'(e.widx * 4)); end
    end
    if (rsp_vld[g]) begin
      chk("resp_owner", g, {31'b0, have}, 32'd1);
      if (have) begin
        if (g == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        chk("resp_exc", g, {31'b0, rsp_exc[g]}, {31'b0, e.exc});
        chk("resp_data", g, rsp_dat[g], e.data);
        chk("resp_cycle", g, cyc, e.cyc);
        chk("n_reads", g, nrd[g], e.nrd);
        chk("n_writes", g, nwr[g], e.nwr);
        mchk[g] = 1'b1; mw[g] = e.widx; mword[g] = e.word;
      end
      nrd[g] = 0; nwr[g] = 0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) mon_step(g);
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached with %0d/%0d responses pending", q0.size(), q1.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    logic [1:0] sz;
    int t;
    for (int g = 0; g < 2; g++) for (int i = 0; i < 1024; i++) mb[g][i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Word store then load back
    do_op(1, MEM_SZ_W, 0, 32'h100, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    do_op(0, MEM_SZ_W, 0, 32'h100, '0, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    // Lane extraction / extension
    do_op(1, MEM_SZ_W, 0, 32'h200, 32'h80FF7F01, 1, 32'h80FF7F01, 1, 32'h80FF7F01);
    do_op(0, MEM_SZ_B, 1, 32'h201, '0, 1, 32'h0000007F, 0, '0);
    do_op(0, MEM_SZ_B, 1, 32'h203, '0, 1, 32'hFFFFFF80, 0, '0);
    do_op(0, MEM_SZ_B, 0, 32'h202, '0, 1, 32'h000000FF, 0, '0);
    do_op(0, MEM_SZ_H, 1, 32'h202, '0, 1, 32'hFFFF80FF, 0, '0);
    do_op(0, MEM_SZ_H, 0, 32'h202, '0, 1, 32'h000080FF, 0, '0);
    do_op(0, MEM_SZ_B, 1, 32'h200, '0, 0, '0, 1, 32'hFFFFFF80);
    // Read-modify-write
    do_op(1, MEM_SZ_W, 0, 32'h200, 32'h11223344, 1, 32'h11223344, 1, 32'h11223344);
    do_op(1, MEM_SZ_B, 0, 32'h202, 32'h000000AB, 1, 32'h11AB3344, 0, '0);
    do_op(1, MEM_SZ_H, 0, 32'h200, 32'h0000CDEF, 1, 32'h11ABCDEF, 0, '0);
    // Exceptions: no memory traffic
    op(0, MEM_SZ_W, 0, 32'h102, '0);
    op(0, MEM_SZ_H, 1, 32'h101, '0);
    op(1, MEM_SZ_ILL, 0, 32'h100, 32'h12345678);
    op(1, MEM_SZ_H, 0, 32'h103, 32'h0000FFFF);
    // Reset in the middle of an RMW, then a normal access
    abort_rmw(32'h201);
    do_op(0, MEM_SZ_W, 0, 32'h200, '0, 1, 32'h11ABCDEF, 0, '0);
    // Initialise every word, then random traffic
    for (int w = 0; w < 256; w++) op(1, MEM_SZ_W, 0, w * 4, $urandom);
    for (int i = 0; i < 10000; i++) begin
      t = $urandom_range(0, 15);
      sz = (t < 5) ? MEM_SZ_B : (t < 10) ? MEM_SZ_H : (t < 15) ? MEM_SZ_W : MEM_SZ_ILL;
      a = $urandom_range(0, 1023);
      if ($urandom_range(0, 7) != 0) begin
        if (sz == MEM_SZ_H) a = a & ~1;
        if (sz == MEM_SZ_W) a = a & ~3;
      end
      op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
    end
    req_valid = 1'b0;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk("drain", 0, q0.size() + q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
